// File: rtl/softmax_argmax.sv
// -----------------------------------------------------------------------------
// softmax_argmax
//
// Purpose:
//   Downstream stage of the layer-2 multiply/accumulate store. When start is
//   seen in IDLE the packed vector of NODES signed sums is copied into a local
//   snapshot. That vector is then scanned one node per clock. The index and
//   value of the largest sum are reported as the network's classification.
//   Because of the snapshot, the upstream accumulator can be cleared and
//   reloaded while the scan is still running.
//
// Parameters:
//   NODES        number of output nodes (>= 1)
//   SUM_WIDTH    width of each two's-complement sum
//   INDEX_WIDTH  width of the class index (2**INDEX_WIDTH >= NODES)
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   clr       in   synchronous active-high reset
//   start     in   scan request, sampled only in IDLE
//   sumIn     in   packed sums, node i at [i*SUM_WIDTH +: SUM_WIDTH]
//   busy      out  high whenever the block is not IDLE
//   done      out  one-cycle pulse when a scan completes
//   classOut  out  index of the maximum from the last completed scan
//   maxValue  out  value of the maximum from the last completed scan
// -----------------------------------------------------------------------------
module softmax_argmax #(
  parameter int NODES       = 10,
  parameter int SUM_WIDTH   = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       start,
  input  logic [NODES*SUM_WIDTH-1:0] sumIn,
  output logic                       busy,
  output logic                       done,
  output logic [INDEX_WIDTH-1:0]     classOut,
  output logic [SUM_WIDTH-1:0]       maxValue
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  // Index of the final node. Reaching it ends the scan.
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NODES - 1);

  state_t                        r_state;
  logic signed [SUM_WIDTH-1:0]   r_snap [NODES];
  logic signed [SUM_WIDTH-1:0]   r_best_val;
  logic [INDEX_WIDTH-1:0]        r_best_idx;
  logic [INDEX_WIDTH-1:0]        r_scan_idx;
  logic                          r_busy;
  logic                          r_done;
  logic [INDEX_WIDTH-1:0]        r_class;
  logic [SUM_WIDTH-1:0]          r_max;

  logic signed [SUM_WIDTH-1:0]   w_node0;
  logic signed [SUM_WIDTH-1:0]   w_cur;
  logic                          w_greater;
  logic signed [SUM_WIDTH-1:0]   w_next_val;
  logic [INDEX_WIDTH-1:0]        w_next_idx;
  logic                          w_last;

  assign busy     = r_busy;
  assign done     = r_done;
  assign classOut = r_class;
  assign maxValue = r_max;

  // Node 0 seeds the running best on the start edge. It is taken straight
  // from the input because the snapshot is being written on that same edge.
  assign w_node0 = sumIn[SUM_WIDTH-1:0];
  assign w_last  = (r_scan_idx == LAST_IDX);

  // Select the node under the scan index and form the next running best.
  // A strict greater-than keeps the lower index when two sums are equal.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_cur = '0;
    for (int i = 0; i < NODES; i++) begin
      if (r_scan_idx == INDEX_WIDTH'(i)) begin
        w_cur = r_snap[i];
      end
    end
    w_greater  = (w_cur > r_best_val);
    w_next_val = w_greater ? w_cur : r_best_val;
    w_next_idx = w_greater ? r_scan_idx : r_best_idx;
  end

  // Single controller. State, snapshot, running best and the registered
  // outputs are all updated here.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the snapshot array is reset explicitly, so a scan aborted by
      // clr leaves no stale data behind. A RAM-style array is normally left
      // unreset.
      r_state    <= S_IDLE;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_scan_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_class    <= '0;
      r_max      <= '0;
      for (int i = 0; i < NODES; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // right-hand side therefore sees the value from before the edge.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NODES; i++) begin
              r_snap[i] <= sumIn[i*SUM_WIDTH +: SUM_WIDTH];
            end
            r_best_val <= w_node0;
            r_best_idx <= '0;
            r_scan_idx <= INDEX_WIDTH'(1);
            r_busy     <= 1'b1;
            if (NODES == 1) begin
              // A single node is the maximum already, so the scan is skipped.
              r_class <= '0;
              r_max   <= w_node0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
          r_best_val <= w_next_val;
          r_best_idx <= w_next_idx;
          if (w_last) begin
            // The outputs change only on this edge and then hold until the
            // next completed scan.
            r_class <= w_next_idx;
            r_max   <= w_next_val;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + INDEX_WIDTH'(1);
          end
        end

        S_DONE: begin
          // start is not looked at here, so a request made during DONE is
          // dropped rather than queued.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_argmax.sv
// -----------------------------------------------------------------------------
// tb_softmax_argmax
//
// Testbench for softmax_argmax. The main instance uses 4 nodes of 8-bit sums.
// A second instance is a degenerate 1-node build.
// The stimulus process pushes the expected {class, value} for each scan it
// launches. A monitor pops one entry on every done pulse and compares it.
// Latency, pulse width, abort and ignored-start behaviour are checked inline
// by the stimulus process.
// -----------------------------------------------------------------------------
module tb_softmax_argmax;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  typedef struct {
    int cls;
    int val;
  } exp_t;

  logic            clk;
  logic            clr;
  logic            start;
  logic [N*W-1:0]  sum_in;
  logic            busy;
  logic            done;
  logic [IW-1:0]   class_out;
  logic [W-1:0]    max_value;

  logic            start1;
  logic [W-1:0]    sum_in1;
  logic            busy1;
  logic            done1;
  logic [0:0]      class1;
  logic [W-1:0]    max1;

  exp_t q[$];
  int   done_times[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cnt = 0;

  softmax_argmax #(.NODES(N), .SUM_WIDTH(W), .INDEX_WIDTH(IW)) u_dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .sumIn    (sum_in),
    .busy     (busy),
    .done     (done),
    .classOut (class_out),
    .maxValue (max_value)
  );

  softmax_argmax #(.NODES(1), .SUM_WIDTH(W), .INDEX_WIDTH(1)) u_dut1 (
    .clk      (clk),
    .clr      (clr),
    .start    (start1),
    .sumIn    (sum_in1),
    .busy     (busy1),
    .done     (done1),
    .classOut (class1),
    .maxValue (max1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pack node values, with node 0 in the LSBs.
  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count the edges from the start edge until done rises. The count is bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", {31'b0, done}, 1);
  endtask

  task automatic launch(input logic [N*W-1:0] v, input int cls, input int val);
    sum_in = v;
    q.push_back('{cls: cls, val: val});
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor / scoreboard. It samples on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (q.size() == 0) begin
        check("done_without_expectation", {31'b0, done}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_class", $signed({1'b0, class_out}), e.cls);
        check("sb_value", $signed(max_value), e.val);
      end
    end
  end

  initial begin
    int n;
    int dc;
    clr     = 1'b1;
    start   = 1'b0;
    sum_in  = '0;
    start1  = 1'b0;
    sum_in1 = '0;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_class", $signed({1'b0, class_out}), 0);
    check("rst_max", $signed(max_value), 0);
    check("rst1_busy", {31'b0, busy1}, 0);
    clr = 1'b0;
    tick();

    // Basic argmax. done rises N-1 edges after the start edge, for N busy
    // cycles in all.
    launch(pk(5, -3, 17, 9), 2, 17);
    check("basic_busy_after_start", {31'b0, busy}, 1);
    wait_done(n);
    check("basic_latency", n, N - 1);
    check("basic_busy_in_done", {31'b0, busy}, 1);
    tick();
    check("basic_done_one_cycle", {31'b0, done}, 0);
    check("basic_busy_idle", {31'b0, busy}, 0);
    check("basic_class_hold", $signed({1'b0, class_out}), 2);
    check("basic_max_hold", $signed(max_value), 17);

    // The most negative sum, plus a tie that keeps the lower index.
    launch(pk(-128, -1, -1, -50), 1, -1);
    wait_done(n);
    tick();

    // All sums equal to zero.
    launch(pk(0, 0, 0, 0), 0, 0);
    wait_done(n);
    tick();

    // sumIn changes and start is pulsed again mid-scan. Both have no effect.
    dc = done_cnt;
    launch(pk(1, 2, 3, 4), 3, 4);
    sum_in = pk(100, 0, 0, 0);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(n);
    // start raised during DONE is dropped as well.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("ignored_start_one_done", done_cnt - dc, 1);
    check("ignored_start_idle", {31'b0, busy}, 0);

    // clr is asserted at the second SCAN edge and aborts the scan.
    dc = done_cnt;
    sum_in = pk(7, 8, 9, 10);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_class", $signed({1'b0, class_out}), 0);
    check("abort_max", $signed(max_value), 0);
    repeat (6) tick();
    check("abort_no_done", done_cnt - dc, 0);
    launch(pk(-5, -7, -2, -9), 2, -2);
    wait_done(n);
    check("after_abort_latency", n, N - 1);
    tick();

    // start held high: one capture every 5 cycles, each with a new vector.
    done_times.delete();
    sum_in = pk(1, 9, 3, 2);
    q.push_back('{cls: 1, val: 9});
    start = 1'b1;
    tick();
    sum_in = pk(-1, -2, -3, 0);
    q.push_back('{cls: 3, val: 0});
    repeat (5) tick();
    sum_in = pk(4, 4, 4, 4);
    q.push_back('{cls: 0, val: 4});
    repeat (5) tick();
    start = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    tick();
    check("b2b_done_count", done_times.size(), 3);
    if (done_times.size() >= 3) begin
      check("b2b_period_1", done_times[1] - done_times[0], 5);
      check("b2b_period_2", done_times[2] - done_times[1], 5);
    end

    // 1-node build: done follows on the very next cycle.
    sum_in1 = 8'hB3;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    check("n1_done", {31'b0, done1}, 1);
    check("n1_busy", {31'b0, busy1}, 1);
    check("n1_class", $signed({1'b0, class1}), 0);
    check("n1_max", $signed(max1), -77);
    tick();
    check("n1_done_one_cycle", {31'b0, done1}, 0);
    check("n1_max_hold", $signed(max1), -77);
    sum_in1 = 8'h7F;
    start1  = 1'b1;
    tick();
    start1  = 1'b0;
    check("n1_done_2", {31'b0, done1}, 1);
    check("n1_max_2", $signed(max1), 127);
    tick();

    check("sb_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
